pass_through_in_queue: RTL and testbench
========================================

Name: pass_through_in_queue

Overview:
- Elastic input buffer placed directly upstream of the 10-bit pass-through stage; its io_deq_bits output drives that stage's io_in.
- Absorbs bursty producer traffic with a valid/ready handshake on both sides.
- Holds up to DEPTH words in FIFO order and reports occupancy.
- Non-flow, non-pipe queue: registered output, no same-cycle bypass.

Parameters:
- WIDTH, 10, data word width in bits; matches the pass-through stage.
- DEPTH, 4, number of storage entries; power of two, minimum 2.
- PTR_W, log2(DEPTH), read/write pointer width; derived, not overridable.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when 0, deasserted synchronously by the system.
- io_enq_valid  input  1  producer offers io_enq_bits this cycle.
- io_enq_ready  output  1  queue accepts a word this cycle.
- io_enq_bits  input  WIDTH  producer data.
- io_deq_valid  output  1  io_deq_bits holds the oldest stored word.
- io_deq_ready  input  1  consumer takes the word this cycle.
- io_deq_bits  output  WIDTH  oldest stored word; feeds pass-through io_in.
- io_count  output  PTR_W+1  current occupancy, range 0..DEPTH.

Behaviour:
- State: storage array of DEPTH x WIDTH, wr_ptr, rd_ptr (PTR_W bits each), count (PTR_W+1 bits).
- Reset (reset==0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: io_enq_ready=1, io_deq_valid=0, io_count=0.
  - Storage is not cleared.
  - Reset asserted mid-operation discards all stored words immediately.
- Flags, combinational from count only:
  - io_enq_ready = (count != DEPTH).
  - io_deq_valid = (count != 0).
  - io_count = count.
- Handshake:
  - enq fires when io_enq_valid && io_enq_ready.
  - deq fires when io_deq_valid && io_deq_ready.
  - Each fire is one transfer.
- On enq fire: mem[wr_ptr] <= io_enq_bits; wr_ptr <= wr_ptr+1 (mod DEPTH).
- On deq fire: rd_ptr <= rd_ptr+1 (mod DEPTH).
- Count update:
  - +1 on enq only; -1 on deq only.
  - Unchanged on both or neither.
- io_deq_bits = mem[rd_ptr], combinational read. Value is don't-care when io_deq_valid=0 (bench checks only when valid).
- Latency: a word enqueued in cycle N is first visible on io_deq with io_deq_valid=1 in cycle N+1. No same-cycle bypass when empty.
- Full (count==DEPTH): io_enq_ready=0 even if io_deq_ready=1 the same cycle (no pipe-through). Space frees the cycle after a deq.
- Empty (count==0): io_deq_valid=0. io_enq_valid alone enqueues; nothing dequeues.
- Simultaneous enq+deq with 0<count<DEPTH: both occur, count constant, order preserved.
- Pointer wrap: pointers roll DEPTH-1 -> 0 with no bubble. Full and empty are distinguished by count, not pointer equality.
- Producer may change io_enq_bits freely while io_enq_ready=0; nothing is captured.
- Not required to hold io_enq_valid.
- Decoupled rule: io_enq_ready never depends on io_enq_valid, and io_deq_valid never depends on io_deq_ready (no combinational loops).

Decomposition:
- Shared package:
  - WORD_W=10 (common data width used by this queue and the pass-through stage).
  - Default DEPTH=4.
  - Helper function for pointer width (log2).
- One natural sub-module: queue_wrap_counter (PTR_W-bit counter with increment enable, mod-DEPTH wrap, async active-low clear), instantiated twice for wr_ptr and rd_ptr.
- Storage and count logic stay in the top.

Test Plan:
- Reset: drive reset=0 mid-stream with count=3 -> io_count=0, io_deq_valid=0, io_enq_ready=1 immediately (async). After release, first enqueued word 0x155 appears at deq one cycle later.
- Fill to full, deq_ready=0:
  - Enqueue 0x001,0x002,0x003,0x004 -> io_count reaches 4 and io_enq_ready=0.
  - A fifth word 0x3FF offered for 3 cycles is not captured; io_count stays 4.
- Drain order: from full, hold io_deq_ready=1 -> io_deq_bits=0x001,0x002,0x003,0x004 on consecutive cycles, then io_deq_valid=0 and io_count=0.
- Latency from empty: enq 0x2AA in cycle N with io_deq_ready=1 -> io_deq_valid=0 in N, valid with 0x2AA in N+1, empty in N+2.
- Simultaneous enq/deq at count=2: 20 cycles of both fires with incrementing data 0x010.. -> io_count stays 2, output sequence is strictly in order, and pointers wrap at least 5 times without loss.
- Full-with-deq: at count=4, assert io_deq_ready=1 and io_enq_valid=1 -> only the deq fires (count 3). Next cycle io_enq_ready=1 and the enq is accepted.

Source files
------------

// File: rtl/pass_through_in_queue_pkg.sv
// Shared definitions for the pass-through input queue and its neighbouring stage.
// Holds the common word width, the default queue depth and the pointer-width helper.
package pass_through_in_queue_pkg;

  localparam int WORD_W        = 10;
  localparam int DEFAULT_DEPTH = 4;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pass_through_in_queue_wrap_counter.sv
// Modulo-DEPTH pointer counter with increment enable and async active-low clear.
// Updates one cycle after i_inc is sampled high; never stalls.
module queue_wrap_counter
  import pass_through_in_queue_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_cnt
);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_next;

  // Explicit wrap keeps the pointer correct even if DEPTH stops being a power of two.
  assign w_next = (r_cnt == LAST) ? '0 : (r_cnt + PTR_ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pass_through_in_queue.sv
// Elastic DEPTH-entry FIFO feeding the pass-through stage; enq-to-deq latency one cycle, no bypass.
// Backpressure: enq_ready drops only when full (no pipe-through), deq_valid only when empty.
module pass_through_in_queue
  import pass_through_in_queue_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [PTR_W:0]   io_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_enq_fire;
  logic             w_deq_fire;

  // Flags come from the registered count only, so neither side sees the other's handshake.
  assign io_enq_ready = (r_count != FULL_CNT);
  assign io_deq_valid = (r_count != '0);
  assign io_count     = r_count;

  assign w_enq_fire = io_enq_valid && io_enq_ready;
  assign w_deq_fire = io_deq_valid && io_deq_ready;

  queue_wrap_counter #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .i_inc (w_enq_fire),
    .o_cnt (w_wr_ptr)
  );

  queue_wrap_counter #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .i_inc (w_deq_fire),
    .o_cnt (w_rd_ptr)
  );

  // Storage is deliberately left unreset; count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_enq_fire) begin
      r_mem[w_wr_ptr] <= io_enq_bits;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_deq_bits = r_mem[w_rd_ptr];

endmodule

// File: tb/tb_pass_through_in_queue.sv
// Self-checking bench for pass_through_in_queue: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_pass_through_in_queue;
  import pass_through_in_queue_pkg::*;

  localparam int W = WORD_W;
  localparam int D = DEFAULT_DEPTH;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_enq_valid = 1'b0;
  logic         io_enq_ready;
  logic [W-1:0] io_enq_bits = '0;
  logic         io_deq_valid;
  logic         io_deq_ready = 1'b0;
  logic [W-1:0] io_deq_bits;
  logic [2:0]   io_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] mq[$];

  typedef struct {
    logic         ev;
    logic [W-1:0] eb;
    logic         dr;
    int           ecnt;
    logic         eer;
    logic         edv;
    logic [W-1:0] edb;
  } vec_t;

  vec_t vt[15];

  pass_through_in_queue dut (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Compare against the reference queue, then apply this cycle's transfers to it.
  task automatic model_step(input string tag);
    bit enq_f, deq_f;
    chk({tag, " count"}, int'(io_count), mq.size());
    chk({tag, " enq_ready"}, int'(io_enq_ready), int'(mq.size() < D));
    chk({tag, " deq_valid"}, int'(io_deq_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, " deq_bits"}, int'(io_deq_bits), int'(mq[0]));
    enq_f = io_enq_valid && (mq.size() < D);
    deq_f = io_deq_ready && (mq.size() > 0);
    if (deq_f) void'(mq.pop_front());
    if (enq_f) mq.push_back(io_enq_bits);
  endtask

  task automatic drive(input logic ev, input logic [W-1:0] eb, input logic dr);
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
  endtask

  task automatic cyc(input logic ev, input logic [W-1:0] eb, input logic dr, input string tag);
    drive(ev, eb, dr);
    @(negedge clock);
    model_step(tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 10'h001, 1'b0, 0, 1'b1, 1'b0, 10'h000};
    vt[1]  = '{1'b1, 10'h002, 1'b0, 1, 1'b1, 1'b1, 10'h001};
    vt[2]  = '{1'b1, 10'h003, 1'b0, 2, 1'b1, 1'b1, 10'h001};
    vt[3]  = '{1'b1, 10'h004, 1'b0, 3, 1'b1, 1'b1, 10'h001};
    vt[4]  = '{1'b1, 10'h3FF, 1'b0, 4, 1'b0, 1'b1, 10'h001};
    vt[5]  = '{1'b1, 10'h3FF, 1'b0, 4, 1'b0, 1'b1, 10'h001};
    vt[6]  = '{1'b1, 10'h3FF, 1'b0, 4, 1'b0, 1'b1, 10'h001};
    vt[7]  = '{1'b0, 10'h000, 1'b1, 4, 1'b0, 1'b1, 10'h001};
    vt[8]  = '{1'b0, 10'h000, 1'b1, 3, 1'b1, 1'b1, 10'h002};
    vt[9]  = '{1'b0, 10'h000, 1'b1, 2, 1'b1, 1'b1, 10'h003};
    vt[10] = '{1'b0, 10'h000, 1'b1, 1, 1'b1, 1'b1, 10'h004};
    vt[11] = '{1'b0, 10'h000, 1'b0, 0, 1'b1, 1'b0, 10'h000};
    vt[12] = '{1'b1, 10'h2AA, 1'b1, 0, 1'b1, 1'b0, 10'h000};
    vt[13] = '{1'b0, 10'h000, 1'b1, 1, 1'b1, 1'b1, 10'h2AA};
    vt[14] = '{1'b0, 10'h000, 1'b0, 0, 1'b1, 1'b0, 10'h000};

    // Reset state while held in reset.
    #2;
    chk("rst count", int'(io_count), 0);
    chk("rst enq_ready", int'(io_enq_ready), 1);
    chk("rst deq_valid", int'(io_deq_valid), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Fill, full hold, drain order, latency from empty.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].ev, vt[i].eb, vt[i].dr);
      @(negedge clock);
      chk($sformatf("vec%0d count", i), int'(io_count), vt[i].ecnt);
      chk($sformatf("vec%0d enq_ready", i), int'(io_enq_ready), int'(vt[i].eer));
      chk($sformatf("vec%0d deq_valid", i), int'(io_deq_valid), int'(vt[i].edv));
      if (vt[i].edv) chk($sformatf("vec%0d deq_bits", i), int'(io_deq_bits), int'(vt[i].edb));
      model_step($sformatf("vec%0d model", i));
      @(posedge clock);
      #1;
    end

    // Simultaneous enq/deq at count 2 across several pointer wraps.
    cyc(1'b1, 10'h010, 1'b0, "sim pre0");
    cyc(1'b1, 10'h011, 1'b0, "sim pre1");
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, W'(10'h012 + i), 1'b1);
      @(negedge clock);
      chk($sformatf("sim%0d count", i), int'(io_count), 2);
      chk($sformatf("sim%0d bits", i), int'(io_deq_bits), 16'h010 + i);
      model_step($sformatf("sim%0d model", i));
      @(posedge clock);
      #1;
    end
    cyc(1'b0, 10'h000, 1'b1, "sim drain0");
    cyc(1'b0, 10'h000, 1'b1, "sim drain1");
    cyc(1'b0, 10'h000, 1'b0, "sim empty");

    // Full with deq_ready: only the deq fires, space appears next cycle.
    for (int i = 0; i < D; i++) cyc(1'b1, W'(10'h0A0 + i), 1'b0, "fwd fill");
    drive(1'b1, 10'h0AA, 1'b1);
    @(negedge clock);
    chk("fwd full enq_ready", int'(io_enq_ready), 0);
    chk("fwd full count", int'(io_count), 4);
    model_step("fwd full");
    @(posedge clock);
    #1;
    drive(1'b1, 10'h0AA, 1'b0);
    @(negedge clock);
    chk("fwd after count", int'(io_count), 3);
    chk("fwd after enq_ready", int'(io_enq_ready), 1);
    model_step("fwd after");
    @(posedge clock);
    #1;
    for (int i = 0; i < D; i++) cyc(1'b0, 10'h000, 1'b1, "fwd drain");
    cyc(1'b0, 10'h000, 1'b0, "fwd empty");

    // Asynchronous reset mid-stream with three words stored.
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(10'h300 + i), 1'b0, "ars fill");
    drive(1'b0, 10'h000, 1'b0);
    @(negedge clock);
    chk("ars pre count", int'(io_count), 3);
    #1 reset = 1'b0;
    #1;
    chk("ars count", int'(io_count), 0);
    chk("ars deq_valid", int'(io_deq_valid), 0);
    chk("ars enq_ready", int'(io_enq_ready), 1);
    mq.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, 10'h155, 1'b0);
    @(negedge clock);
    chk("ars N deq_valid", int'(io_deq_valid), 0);
    model_step("ars N");
    @(posedge clock);
    #1;
    drive(1'b0, 10'h000, 1'b1);
    @(negedge clock);
    chk("ars N+1 deq_valid", int'(io_deq_valid), 1);
    chk("ars N+1 bits", int'(io_deq_bits), 16'h155);
    model_step("ars N+1");
    @(posedge clock);
    #1;

    // Randomized traffic; bias shifts so both full and empty are visited.
    for (int i = 0; i < 600; i++) begin
      logic ev, dr;
      if (i < 200) begin
        ev = ($urandom_range(0, 3) != 0);
        dr = ($urandom_range(0, 3) == 0);
      end else if (i < 400) begin
        ev = ($urandom_range(0, 3) == 0);
        dr = ($urandom_range(0, 3) != 0);
      end else begin
        ev = $urandom_range(0, 1) == 1;
        dr = $urandom_range(0, 1) == 1;
      end
      cyc(ev, W'($urandom), dr, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
